cgra_mp_arbiter: RTL and testbench

Round-robin arbiter that merges the CGRA's `MP` OBI master ports onto a single OBI master port toward the system bus. It sits between `cgra_top_wrapper`'s `masters_req_o`/`masters_resp_i` and one crossbar slave port. It tracks the originator of every outstanding transaction so that in-order responses are returned to the correct requester.

---
 rtl/cgra_mp_arbiter.sv | 158 +++++++++++++++
 tb/tb_cgra_mp_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cgra_mp_arbiter.sv
// cgra_mp_arbiter
// Round-robin merge of the CGRA's OBI master ports onto one downstream OBI
// master port. An ID FIFO records which port issued each granted
// transaction, so that in-order responses are routed back to that port.
//
// Ports
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   req_i   : upstream requests, one per CGRA port
//   resp_o  : upstream responses (grant, rvalid, rdata)
//   req_o   : merged downstream request
//   resp_i  : downstream response
//   busy_o  : an outstanding transaction exists or any port is requesting
//   err_o   : sticky; set when rvalid arrives with nothing outstanding
//
// Handshake semantics: a request transfers in the cycle where req=1 and
// gnt=1. Once req_o.req is raised it is held with unchanged fields until
// gnt. rvalid is a single-cycle pulse with no back-pressure, and responses
// return in issue order.

package cgra_pkg;
  localparam int unsigned MP = 4;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module cgra_mp_arbiter
  import cgra_pkg::*;
#(
  parameter int unsigned N_REQ   = cgra_pkg::MP,
  parameter int unsigned MAX_OUT = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  obi_req_t  [N_REQ-1:0] req_i,
  output obi_resp_t [N_REQ-1:0] resp_o,
  output obi_req_t              req_o,
  input  obi_resp_t             resp_i,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW = $clog2(MAX_OUT + 1);
  localparam int unsigned FW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] lock_idx;
  logic          lock;
  logic [CW-1:0] count;
  logic [FW-1:0] wr_ptr;
  logic [FW-1:0] rd_ptr;
  logic [PW-1:0] id_fifo [MAX_OUT];

  logic [PW-1:0] rr_sel;
  logic          rr_found;
  logic [PW-1:0] sel;
  logic [PW-1:0] head;
  logic          can_issue;
  logic          push;
  logic          pop;
  logic          any_req;

  function automatic logic [FW-1:0] fifo_inc(input logic [FW-1:0] p);
    return (32'(p) == MAX_OUT - 1) ? '0 : FW'(32'(p) + 1);
  endfunction

  function automatic logic [PW-1:0] port_inc(input logic [PW-1:0] p);
    return (32'(p) == N_REQ - 1) ? '0 : PW'(32'(p) + 1);
  endfunction

  // First requesting port at or after ptr, wrapping. Falls back to port 0.
  always_comb begin
    logic [PW-1:0] idx;
    rr_sel   = '0;
    rr_found = 1'b0;
    any_req  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = PW'((32'(ptr) + 32'(k)) % N_REQ);
      if (!rr_found && req_i[idx].req) begin
        rr_found = 1'b1;
        rr_sel   = idx;
      end
      any_req = any_req | req_i[k].req;
    end
  end

  // A stalled request keeps its port so req_o stays stable until granted.
  assign sel       = lock ? lock_idx : rr_sel;
  assign can_issue = (count < CW'(MAX_OUT));
  assign head      = id_fifo[rd_ptr];

  always_comb begin
    req_o     = req_i[sel];
    req_o.req = req_i[sel].req & can_issue;
  end

  assign push = req_o.req & resp_i.gnt;
  assign pop  = resp_i.rvalid & (count != '0);

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      resp_o[i].gnt    = push & (sel == PW'(i));
      resp_o[i].rvalid = pop & (head == PW'(i));
      resp_o[i].rdata  = resp_i.rdata;
    end
  end

  assign busy_o = (count != '0) | any_req;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr      <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      err_o    <= 1'b0;
    end else begin
      // Lock follows "offered but not granted"; a handshake clears it.
      lock <= req_o.req & ~resp_i.gnt;
      if (req_o.req & ~resp_i.gnt) lock_idx <= sel;

      if (push) begin
        ptr    <= port_inc(sel);
        wr_ptr <= fifo_inc(wr_ptr);
      end
      if (pop) rd_ptr <= fifo_inc(rd_ptr);

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (resp_i.rvalid && count == '0) err_o <= 1'b1;
    end
  end

  // ID storage needs no reset: entries are only read once written.
  always_ff @(posedge clk_i) begin
    if (push) id_fifo[wr_ptr] <= sel;
  end

endmodule

// File: tb/tb_cgra_mp_arbiter.sv
module tb_cgra_mp_arbiter;
  import cgra_pkg::*;

  localparam int NP = 4;
  localparam int MO = 2;

  logic clk;
  logic rst_n;
  obi_req_t  [NP-1:0] req_i;
  obi_resp_t [NP-1:0] resp_o;
  obi_req_t           req_o;
  obi_resp_t          resp_i;
  logic               busy;
  logic               err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state; the queue holds the issuing port of each
  // outstanding transaction in issue order.
  logic [1:0] exp_q[$];
  logic [1:0] m_ptr;
  logic       m_lock;
  logic [1:0] m_lock_idx;
  logic       m_err;

  logic [31:0] s_addr [NP];
  logic [31:0] s_wdata[NP];
  logic [3:0]  s_be   [NP];
  logic        s_we   [NP];

  cgra_mp_arbiter #(.N_REQ(NP), .MAX_OUT(MO)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .req_i  (req_i),
    .resp_o (resp_o),
    .req_o  (req_o),
    .resp_i (resp_i),
    .busy_o (busy),
    .err_o  (err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < NP; i++) req_i[i] = '0;
    resp_i = '0;
  endtask

  // Called just after a rising edge; asserts reset mid-cycle.
  task automatic do_reset();
    #3;
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("rst_req", {31'b0, req_o.req}, 32'd0);
    for (int i = 0; i < NP; i++) begin
      chk($sformatf("rst_gnt%0d", i), {31'b0, resp_o[i].gnt}, 32'd0);
      chk($sformatf("rst_rv%0d", i), {31'b0, resp_o[i].rvalid}, 32'd0);
    end
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    exp_q.delete();
    m_ptr = 2'd0; m_lock = 1'b0; m_lock_idx = 2'd0; m_err = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
  endtask

  // ---------------- driver + scoreboard step ----------------
  task automatic step(input logic [3:0] reqs, input logic gnt, input logic rv);
    logic [1:0]  es;
    logic [1:0]  idx;
    logic        found;
    logic        ereq;
    logic [31:0] rd;
    int          cnt;
    #1;
    cyc++;
    rd = $urandom;
    for (int i = 0; i < NP; i++) begin
      s_addr[i]  = 32'h1000 + 32'(i) * 32'h100 + 32'(cyc) * 4;
      s_wdata[i] = $urandom;
      s_be[i]    = 4'($urandom_range(0, 15));
      s_we[i]    = 1'($urandom_range(0, 1));
      req_i[i].req   = reqs[i];
      req_i[i].addr  = s_addr[i];
      req_i[i].wdata = s_wdata[i];
      req_i[i].be    = s_be[i];
      req_i[i].we    = s_we[i];
    end
    resp_i.gnt    = gnt;
    resp_i.rvalid = rv;
    resp_i.rdata  = rd;
    #1;
    cnt = exp_q.size();
    if (m_lock) es = m_lock_idx;
    else begin
      es = 2'd0; found = 1'b0;
      for (int k = 0; k < NP; k++) begin
        idx = 2'(m_ptr + 2'(k));
        if (!found && reqs[idx]) begin found = 1'b1; es = idx; end
      end
    end
    ereq = reqs[es] && (cnt < MO);
    chk("req", {31'b0, req_o.req}, {31'b0, ereq});
    chk("addr", req_o.addr, s_addr[es]);
    chk("wdata", req_o.wdata, s_wdata[es]);
    chk("be_we", {27'b0, req_o.be, req_o.we}, {27'b0, s_be[es], s_we[es]});
    for (int i = 0; i < NP; i++) begin
      chk($sformatf("gnt%0d", i), {31'b0, resp_o[i].gnt},
          {31'b0, gnt && ereq && (es == 2'(i))});
      chk($sformatf("rvalid%0d", i), {31'b0, resp_o[i].rvalid},
          {31'b0, rv && (cnt != 0) && (exp_q[0] == 2'(i))});
      if (rv && cnt != 0 && exp_q[0] == 2'(i))
        chk($sformatf("rdata%0d", i), resp_o[i].rdata, rd);
    end
    chk("busy", {31'b0, busy}, {31'b0, (cnt != 0) || (reqs != 4'd0)});
    chk("err", {31'b0, err}, {31'b0, m_err});
    // model update at the coming edge
    if (rv && cnt != 0) void'(exp_q.pop_front());
    if (rv && cnt == 0) m_err = 1'b1;
    if (ereq && gnt) begin
      exp_q.push_back(es);
      m_ptr = 2'(es + 2'd1);
    end
    m_lock     = ereq && !gnt;
    m_lock_idx = es;
    @(posedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    idle_inputs();
    rst_n = 1'b0;
    exp_q.delete();
    m_ptr = 2'd0; m_lock = 1'b0; m_lock_idx = 2'd0; m_err = 1'b0;
    @(posedge clk);
    do_reset();
    step(4'b0000, 1'b0, 1'b0);

    // single port: port 2 read, granted at once, data next cycle
    step(4'b0100, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b1);

    // lock under stall: ptr is 3, ports 1 and 3 request, gnt low 3 cycles
    step(4'b1010, 1'b0, 1'b0);
    step(4'b1010, 1'b0, 1'b0);
    step(4'b1010, 1'b0, 1'b0);
    step(4'b1010, 1'b1, 1'b0);
    step(4'b0010, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);

    // round-robin fairness with rvalid one cycle after each grant
    for (int i = 0; i < 10; i++) step(4'b1111, 1'b1, i > 0);
    step(4'b0000, 1'b0, 1'b1);

    // full throttle: two grants, rvalid held off, then one rvalid
    step(4'b1111, 1'b1, 1'b0);
    step(4'b1111, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(4'b1111, 1'b1, 1'b0);
    step(4'b1111, 1'b1, 1'b1);
    step(4'b1111, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);

    // spurious rvalid sets the sticky error
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);

    // reset with two outstanding, then a stale response
    step(4'b1111, 1'b1, 1'b0);
    step(4'b1111, 1'b1, 1'b0);
    do_reset();
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0);

    // simultaneous push and pop: head is port 0, port 1 granted meanwhile
    do_reset();
    step(4'b0001, 1'b1, 1'b0);
    step(4'b0010, 1'b1, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0);

    // randomized traffic, responses only while something is outstanding
    for (int i = 0; i < 80; i++)
      step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           (exp_q.size() != 0) ? 1'($urandom_range(0, 1)) : 1'b0);
    while (exp_q.size() != 0) step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
